// File: rtl/pipeline_mem_pkg.sv
// Shared definitions for the pipeline_mem responder and the code that talks to it.
// Holds the default geometry, the word/address types, and small helpers
// used to size the storage index and to classify addresses.
package pipeline_mem_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 11;
    localparam int DEPTH_DEF  = 2048;
    localparam int RD_LAT_DEF = 2;

    typedef logic [DATA_W_DEF-1:0] word_t;
    typedef logic [ADDR_W_DEF-1:0] addr_t;

    // True when a word address lies outside an array of the given depth.
    // Callers zero-extend their address to 32 bits, so any ADDR_W up to 32 works.
    function automatic logic addr_out_of_range(input logic [31:0] addr, input int unsigned depth);
        return (addr >= depth);
    endfunction

    // Number of index bits needed to address every word of the array.
    function automatic int unsigned idx_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/mem_rd_pipe.sv
// Read-return pipeline for one memory port.
// The storage array is read at the issue edge into a data register owned by
// the top level; this block carries that word plus a valid tag and an
// out-of-range tag down RD_LAT-1 further stages and lands it in the
// registered output. The output holds its last value until a newer read
// completes; out-of-range reads complete with zero. Legal RD_LAT: 1 or 2.
module mem_rd_pipe
    import pipeline_mem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int RD_LAT = RD_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue,
    input  logic              oor,
    input  logic [DATA_W-1:0] rdata,
    output logic [DATA_W-1:0] dout
);

    logic [RD_LAT-1:0] valid_q;
    logic [RD_LAT-1:0] valid_d;
    logic [RD_LAT-1:0] oor_q;
    logic [RD_LAT-1:0] oor_d;
    logic [DATA_W-1:0] dout_q;
    logic [DATA_W-1:0] dout_d;

    // Word travelling alongside each tag stage; stage 0 is the array read register.
    logic [DATA_W-1:0] stage_data [RD_LAT];

    assign stage_data[0] = rdata;

    // Shift the valid and out-of-range tags one stage per edge; stage 0 samples the new issue.
    always_comb begin
        valid_d    = '0;
        oor_d      = '0;
        valid_d[0] = issue;
        oor_d[0]   = oor;
        for (int i = 1; i < RD_LAT; i++) begin
            valid_d[i] = valid_q[i-1];
            oor_d[i]   = oor_q[i-1];
        end
    end

    // Tag registers; reset drops every read still in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            oor_q   <= '0;
        end else begin
            valid_q <= valid_d;
            oor_q   <= oor_d;
        end
    end

    // Extra data stages beyond the array read register, one per additional cycle of latency.
    genvar gi;
    generate
        for (gi = 1; gi < RD_LAT; gi++) begin : g_stage
            logic [DATA_W-1:0] data_q;
            logic [DATA_W-1:0] data_d;

            // Data simply follows the previous stage; the tags decide whether it is used.
            always_comb begin
                data_d = stage_data[gi-1];
            end

            // Data stage register.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    data_q <= '0;
                end else begin
                    data_q <= data_d;
                end
            end

            assign stage_data[gi] = data_q;
        end
    endgenerate

    // Update the output only when the last stage carries a completed read.
    always_comb begin
        dout_d = dout_q;
        if (valid_q[RD_LAT-1]) begin
            dout_d = oor_q[RD_LAT-1] ? '0 : stage_data[RD_LAT-1];
        end
    end

    // Registered output, so no input reaches dout combinationally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_q <= '0;
        end else begin
            dout_q <= dout_d;
        end
    end

    assign dout = dout_q;

endmodule

// File: rtl/pipeline_mem.sv
// Dual-port synchronous memory responder for the pipeline core.
// Port I is a read-only fetch port, port D reads and writes, and a preload
// port fills the array before the core runs. All three share one array.
// Reads sample the array at the issue edge, so a write at that same edge is
// not yet visible (old data); a read one edge later sees the new word.
// Sticky flags record out-of-range accesses and port-D writes lost to preload.
module pipeline_mem
    import pipeline_mem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int RD_LAT = RD_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    // instruction fetch port
    input  logic              im_oen,
    input  logic [ADDR_W-1:0] I_ADDR,
    output logic [DATA_W-1:0] IR,
    // data port
    input  logic              dm_oen,
    input  logic              dm_wen,
    input  logic [ADDR_W-1:0] D_ADDR,
    input  logic [DATA_W-1:0] D_OUT,
    output logic [DATA_W-1:0] D_IN,
    // preload port
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    // sticky status
    output logic              addr_err,
    output logic              coll_err
);

    // Index bits that select a word; always no wider than ADDR_W since DEPTH <= 2^ADDR_W.
    localparam int IDX_W = idx_width(DEPTH);

    // Shared storage; never reset so it maps onto block RAM.
    logic [DATA_W-1:0] mem_q [DEPTH];

    // Array read registers, one per read port, loaded at the issue edge.
    logic [DATA_W-1:0] i_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;

    logic              i_issue;
    logic              d_issue;
    logic              d_wr_req;
    logic              i_oor;
    logic              d_oor;
    logic              ld_oor;
    logic [IDX_W-1:0]  i_idx;
    logic [IDX_W-1:0]  d_idx;
    logic [IDX_W-1:0]  ld_idx;

    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [DATA_W-1:0] wr_data;

    logic              addr_err_q;
    logic              addr_err_d;
    logic              coll_err_q;
    logic              coll_err_d;

    // Decode the active-low strobes and classify every address against the array depth.
    always_comb begin
        i_issue  = ~im_oen;
        d_issue  = ~dm_oen;
        d_wr_req = ~dm_wen;
        i_oor    = addr_out_of_range(32'(I_ADDR), DEPTH);
        d_oor    = addr_out_of_range(32'(D_ADDR), DEPTH);
        ld_oor   = addr_out_of_range(32'(ld_addr), DEPTH);
        // Truncated indices are only acted on when the matching oor bit is clear.
        i_idx    = I_ADDR[IDX_W-1:0];
        d_idx    = D_ADDR[IDX_W-1:0];
        ld_idx   = ld_addr[IDX_W-1:0];
    end

    // Single write port: preload wins over port D; out-of-range and in-reset writes are dropped.
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = d_idx;
        wr_data = D_OUT;
        if (!rst) begin
            if (ld_en) begin
                wr_en   = ~ld_oor;
                wr_idx  = ld_idx;
                wr_data = ld_data;
            end else if (d_wr_req) begin
                wr_en   = ~d_oor;
            end
        end
    end

    // Array write.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    // Port I array read; non-blocking update gives old data on a same-edge write.
    always_ff @(posedge clk) begin
        if (i_issue) begin
            i_rdata_q <= mem_q[i_idx];
        end
    end

    // Port D array read; same old-data behaviour as port I.
    always_ff @(posedge clk) begin
        if (d_issue) begin
            d_rdata_q <= mem_q[d_idx];
        end
    end

    // Port I return path.
    mem_rd_pipe #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_i_pipe (
        .clk   (clk),
        .rst   (rst),
        .issue (i_issue),
        .oor   (i_oor),
        .rdata (i_rdata_q),
        .dout  (IR)
    );

    // Port D return path.
    mem_rd_pipe #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_d_pipe (
        .clk   (clk),
        .rst   (rst),
        .issue (d_issue),
        .oor   (d_oor),
        .rdata (d_rdata_q),
        .dout  (D_IN)
    );

    // Sticky flags: latch any out-of-range access and any port-D write lost to preload.
    always_comb begin
        addr_err_d = addr_err_q
                   | (i_issue  & i_oor)
                   | ((d_issue | d_wr_req) & d_oor)
                   | (ld_en    & ld_oor);
        coll_err_d = coll_err_q | (ld_en & d_wr_req);
    end

    // Flag registers; only reset clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_err_q <= 1'b0;
            coll_err_q <= 1'b0;
        end else begin
            addr_err_q <= addr_err_d;
            coll_err_q <= coll_err_d;
        end
    end

    assign addr_err = addr_err_q;
    assign coll_err = coll_err_q;

endmodule

// File: tb/tb_pipeline_mem.sv
// Bench for pipeline_mem: two instances (read latency 2 and 1, depth 1024)
// share one directed stimulus stream. A cycle-indexed issue log plus a plain
// array model predicts every output; a negedge process compares each cycle,
// and literal expectations at key points pin the model itself.
module tb_pipeline_mem;
    import pipeline_mem_pkg::*;

    localparam int AW    = 11;
    localparam int DEPTH = 1024;
    localparam int LOGN  = 4096;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           im_oen = 1'b1;
    logic           dm_oen = 1'b1;
    logic           dm_wen = 1'b1;
    logic           ld_en  = 1'b0;
    logic [AW-1:0]  I_ADDR  = '0;
    logic [AW-1:0]  D_ADDR  = '0;
    logic [AW-1:0]  ld_addr = '0;
    word_t          D_OUT   = '0;
    word_t          ld_data = '0;

    word_t ir2, din2, ir1, din1;
    logic  aerr2, cerr2, aerr1, cerr1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipeline_mem #(.DATA_W(32), .ADDR_W(AW), .DEPTH(DEPTH), .RD_LAT(2)) dut (
        .clk(clk), .rst(rst),
        .im_oen(im_oen), .I_ADDR(I_ADDR), .IR(ir2),
        .dm_oen(dm_oen), .dm_wen(dm_wen), .D_ADDR(D_ADDR), .D_OUT(D_OUT), .D_IN(din2),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .addr_err(aerr2), .coll_err(cerr2)
    );

    pipeline_mem #(.DATA_W(32), .ADDR_W(AW), .DEPTH(DEPTH), .RD_LAT(1)) dut1 (
        .clk(clk), .rst(rst),
        .im_oen(im_oen), .I_ADDR(I_ADDR), .IR(ir1),
        .dm_oen(dm_oen), .dm_wen(dm_wen), .D_ADDR(D_ADDR), .D_OUT(D_OUT), .D_IN(din1),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .addr_err(aerr1), .coll_err(cerr1)
    );

    // ---------------- behavioural model ----------------
    word_t m_mem [DEPTH];
    bit    i_iss [LOGN];
    bit    d_iss [LOGN];
    word_t i_val [LOGN];
    word_t d_val [LOGN];
    int    cyc      = 0;
    int    first_ok = 1;
    word_t exp_ir1  = '0, exp_ir2 = '0, exp_din1 = '0, exp_din2 = '0;
    bit    m_aerr   = 1'b0, m_cerr = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_ir1 = '0; exp_ir2 = '0; exp_din1 = '0; exp_din2 = '0;
            m_aerr = 1'b0; m_cerr = 1'b0;
            first_ok = cyc + 1;
        end else if (cyc < LOGN - 1) begin
            cyc = cyc + 1;
            // reads see the array as it was before this edge
            i_iss[cyc] = !im_oen;
            d_iss[cyc] = !dm_oen;
            i_val[cyc] = (int'(I_ADDR) < DEPTH) ? m_mem[I_ADDR[9:0]] : '0;
            d_val[cyc] = (int'(D_ADDR) < DEPTH) ? m_mem[D_ADDR[9:0]] : '0;
            if (ld_en) begin
                if (int'(ld_addr) < DEPTH) m_mem[ld_addr[9:0]] = ld_data;
                if (!dm_wen) m_cerr = 1'b1;
            end else if (!dm_wen && int'(D_ADDR) < DEPTH) begin
                m_mem[D_ADDR[9:0]] = D_OUT;
            end
            if ((!im_oen && int'(I_ADDR) >= DEPTH) ||
                ((!dm_oen || !dm_wen) && int'(D_ADDR) >= DEPTH) ||
                (ld_en && int'(ld_addr) >= DEPTH))
                m_aerr = 1'b1;
            // a read issued at cycle c surfaces at c+latency unless reset intervened
            if (cyc - 1 >= first_ok && i_iss[cyc-1]) exp_ir1  = i_val[cyc-1];
            if (cyc - 2 >= first_ok && i_iss[cyc-2]) exp_ir2  = i_val[cyc-2];
            if (cyc - 1 >= first_ok && d_iss[cyc-1]) exp_din1 = d_val[cyc-1];
            if (cyc - 2 >= first_ok && d_iss[cyc-2]) exp_din2 = d_val[cyc-2];
        end
    end

    task automatic check(input string name, input word_t got, input word_t exp, input bit verbose);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s got=%08h expected=%08h (t=%0t)", name, got, exp, $time);
        end else if (verbose) begin
            $display("ok   %s = %08h", name, got);
        end
    endtask

    // every-cycle comparison against the model, away from the rising edge
    always @(negedge clk) begin
        check("IR_lat2",   ir2,  exp_ir2,  1'b0);
        check("IR_lat1",   ir1,  exp_ir1,  1'b0);
        check("DIN_lat2",  din2, exp_din2, 1'b0);
        check("DIN_lat1",  din1, exp_din1, 1'b0);
        check("aerr_lat2", {31'b0, aerr2}, {31'b0, m_aerr}, 1'b0);
        check("aerr_lat1", {31'b0, aerr1}, {31'b0, m_aerr}, 1'b0);
        check("cerr_lat2", {31'b0, cerr2}, {31'b0, m_cerr}, 1'b0);
        check("cerr_lat1", {31'b0, cerr1}, {31'b0, m_cerr}, 1'b0);
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        im_oen = 1'b1; dm_oen = 1'b1; dm_wen = 1'b1; ld_en = 1'b0;
    endtask

    task automatic preload(input int a, input word_t d);
        ld_en = 1'b1; ld_addr = AW'(a); ld_data = d;
        tick();
        ld_en = 1'b0;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        repeat (3) tick();
        check("reset_IR",   ir2, 32'h0, 1'b1);
        check("reset_DIN",  din2, 32'h0, 1'b1);
        check("reset_aerr", {31'b0, aerr2}, 32'h0, 1'b1);
        check("reset_cerr", {31'b0, cerr2}, 32'h0, 1'b1);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) preload(i, 32'h100 + 32'(i));
        preload(476, 32'h0476_0476);
        for (int i = 0; i < 4; i++) preload(i, 32'(i + 1));

        // streamed fetch of 0..3
        for (int k = 0; k < 6; k++) begin
            if (k < 4) begin im_oen = 1'b0; I_ADDR = AW'(k); end
            else im_oen = 1'b1;
            tick();
            check($sformatf("fetch_lat2_k%0d", k), ir2, (k >= 2) ? 32'(k - 1) : 32'h0, 1'b1);
            check($sformatf("fetch_lat1_k%0d", k), ir1, (k >= 1) ? 32'((k > 4) ? 4 : k) : 32'h0, 1'b1);
        end

        // port-D write with same-edge read, then read-after-write
        dm_wen = 1'b0; dm_oen = 1'b0; D_ADDR = 7; D_OUT = 32'hDEAD_BEEF;
        tick();
        dm_wen = 1'b1;
        tick();
        dm_oen = 1'b1;
        tick();
        check("d_same_edge_old_lat2", din2, 32'h0000_0107, 1'b1);
        check("d_next_new_lat1",      din1, 32'hDEAD_BEEF, 1'b1);
        tick();
        check("d_next_new_lat2",      din2, 32'hDEAD_BEEF, 1'b1);

        // cross-port same edge
        im_oen = 1'b0; I_ADDR = 7; dm_wen = 1'b0; D_ADDR = 7; D_OUT = 32'h0000_1234;
        tick();
        dm_wen = 1'b1;
        tick();
        im_oen = 1'b1;
        tick();
        check("xport_old_lat2", ir2, 32'hDEAD_BEEF, 1'b1);
        check("xport_new_lat1", ir1, 32'h0000_1234, 1'b1);
        tick();
        check("xport_new_lat2", ir2, 32'h0000_1234, 1'b1);

        // preload collides with a port-D write
        ld_en = 1'b1; ld_addr = 5; ld_data = 32'h0000_AAAA;
        dm_wen = 1'b0; D_ADDR = 9; D_OUT = 32'h0000_5555;
        tick();
        idle();
        check("coll_flag_set", {31'b0, cerr2}, 32'h1, 1'b1);
        check("aerr_still_0",  {31'b0, aerr2}, 32'h0, 1'b1);
        dm_oen = 1'b0; D_ADDR = 5;
        tick();
        D_ADDR = 9;
        tick();
        dm_oen = 1'b1;
        tick();
        check("coll_ld_wins", din2, 32'h0000_AAAA, 1'b1);
        tick();
        check("coll_d_dropped", din2, 32'h0000_0109, 1'b1);

        // out-of-range read and write
        dm_oen = 1'b0; D_ADDR = 1500;
        tick();
        dm_oen = 1'b1;
        check("oor_aerr_set", {31'b0, aerr2}, 32'h1, 1'b1);
        tick();
        check("oor_rd_zero_lat1", din1, 32'h0, 1'b1);
        tick();
        check("oor_rd_zero_lat2", din2, 32'h0, 1'b1);
        dm_wen = 1'b0; D_ADDR = 1500; D_OUT = 32'hFFFF_FFFF;
        tick();
        dm_wen = 1'b1; dm_oen = 1'b0; D_ADDR = 476;
        tick();
        D_ADDR = 3;
        tick();
        dm_oen = 1'b1;
        tick();
        check("oor_wr_no_alias", din2, 32'h0476_0476, 1'b1);
        tick();
        check("in_range_after_oor", din2, 32'h0000_0004, 1'b1);
        check("coll_still_set", {31'b0, cerr2}, 32'h1, 1'b1);

        // reset with reads in flight, preload attempted during reset
        im_oen = 1'b0; I_ADDR = 0; dm_oen = 1'b0; D_ADDR = 1;
        tick();
        idle();
        #1;
        rst = 1'b1;
        #1;
        check("midrst_IR_lat2",  ir2,  32'h0, 1'b1);
        check("midrst_IR_lat1",  ir1,  32'h0, 1'b1);
        check("midrst_DIN_lat2", din2, 32'h0, 1'b1);
        check("midrst_DIN_lat1", din1, 32'h0, 1'b1);
        check("midrst_aerr",     {31'b0, aerr2}, 32'h0, 1'b1);
        check("midrst_cerr",     {31'b0, cerr2}, 32'h0, 1'b1);
        ld_en = 1'b1; ld_addr = 2; ld_data = 32'h0000_0BAD;
        tick();
        tick();
        ld_en = 1'b0;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("no_stale_IR_%0d", k),  ir2,  32'h0, 1'b1);
            check($sformatf("no_stale_DIN_%0d", k), din2, 32'h0, 1'b1);
        end
        im_oen = 1'b0; I_ADDR = 2;
        tick();
        im_oen = 1'b1;
        tick();
        check("ld_in_reset_ignored_lat1", ir1, 32'h0000_0003, 1'b1);
        tick();
        check("ld_in_reset_ignored_lat2", ir2, 32'h0000_0003, 1'b1);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
